// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the OpenRAM port-0 sequencer.
// Covers both macro flavours (A: 8-bit address, B: 9-bit address).
package sram_ctrl_pkg;

    localparam int ADDR_W_A         = 8;
    localparam int ADDR_W_B         = 9;
    localparam int DATA_W_DEF       = 32;
    localparam int WMASK_W_DEF      = 4;
    localparam int READ_LAT_DEFAULT = 2;

    typedef logic [0:0] req_id_t;

    localparam req_id_t REQ_WB   = 1'b0;
    localparam req_id_t REQ_TEST = 1'b1;

    // One entry of the read-tag pipe: a read in flight and who issued it.
    typedef struct packed {
        logic    vld;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a last-granted pointer.
// The grant is combinational; the pointer moves only when something is granted.
module rr_arbiter2
    import sram_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_hold,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant,
    output req_id_t    o_grant_id
);

    req_id_t r_last;

    always_comb begin
        o_grant = 2'b00;
        if (!i_hold) begin
            case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = (r_last == REQ_TEST) ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
        o_grant_id = o_grant[1] ? REQ_TEST : REQ_WB;
    end

    // Pointer starts at requester 1 so requester 0 wins the first conflict.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_last <= REQ_TEST;
        end else if (|o_grant) begin
            r_last <= o_grant_id;
        end
    end

endmodule

// File: rtl/sram_port_sequencer.sv
// Shares OpenRAM port 0 between the Wishbone bridge (req 0) and the test engine (req 1).
// One command per clock, registered SRAM controls, and a tag pipe steering read data back.
module sram_port_sequencer
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_A,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WMASK_W  = WMASK_W_DEF,
    parameter int READ_LAT = READ_LAT_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    input  logic                 i_global_csb,
    input  logic [1:0]           i_req_valid,
    input  logic [1:0]           i_req_we,
    input  logic [2*ADDR_W-1:0]  i_req_addr,
    input  logic [2*DATA_W-1:0]  i_req_wdata,
    input  logic [2*WMASK_W-1:0] i_req_wmask,
    output logic [1:0]           o_req_ready,
    output logic [1:0]           o_rsp_valid,
    output logic [DATA_W-1:0]    o_rsp_data,
    output logic                 o_csb0,
    output logic                 o_web0,
    output logic [WMASK_W-1:0]   o_wmask0,
    output logic [ADDR_W-1:0]    o_addr0,
    output logic [DATA_W-1:0]    o_din0,
    input  logic [DATA_W-1:0]    i_dout0
);

    logic [1:0]         w_grant;
    req_id_t            w_id;
    logic               w_hold;
    logic               w_accept;
    logic               w_we;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;
    logic [WMASK_W-1:0] w_wmask;
    tag_t               w_tail;

    logic               r_csb;
    logic               r_web;
    logic [WMASK_W-1:0] r_wmask;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_din;
    tag_t               r_pipe [READ_LAT];
    logic [1:0]         r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;

    // Holding grants while in reset keeps req_ready low for the whole reset window.
    assign w_hold = i_global_csb | ~i_resetn;

    rr_arbiter2 u_arb (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .i_hold     (w_hold),
        .i_valid    (i_req_valid),
        .o_grant    (w_grant),
        .o_grant_id (w_id)
    );

    assign w_accept = |(i_req_valid & w_grant);
    assign w_we     = w_id[0] ? i_req_we[1] : i_req_we[0];
    assign w_addr   = w_id[0] ? i_req_addr[2*ADDR_W-1:ADDR_W]    : i_req_addr[ADDR_W-1:0];
    assign w_wdata  = w_id[0] ? i_req_wdata[2*DATA_W-1:DATA_W]   : i_req_wdata[DATA_W-1:0];
    assign w_wmask  = w_id[0] ? i_req_wmask[2*WMASK_W-1:WMASK_W] : i_req_wmask[WMASK_W-1:0];

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_wmask <= '0;
            r_addr  <= '0;
            r_din   <= '0;
        end else if (w_accept) begin
            r_csb   <= 1'b0;
            r_web   <= ~w_we;
            r_wmask <= w_we ? w_wmask : '0;
            r_addr  <= w_addr;
            r_din   <= w_wdata;
        end else begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_wmask <= '0;
        end
    end

    // Response is captured as the entry leaves the last stage, i.e. READ_LAT edges after accept.
    assign w_tail = r_pipe[READ_LAT-1];

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_pipe[i] <= '0;
            end
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= '0;
        end else begin
            r_pipe[0].vld <= w_accept & ~w_we;
            r_pipe[0].id  <= w_id;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            r_rsp_valid <= {w_tail.vld & w_tail.id[0], w_tail.vld & ~w_tail.id[0]};
            if (w_tail.vld) begin
                r_rsp_data <= i_dout0;
            end
        end
    end

    assign o_req_ready = w_grant;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_csb0      = r_csb;
    assign o_web0      = r_web;
    assign o_wmask0    = r_wmask;
    assign o_addr0     = r_addr;
    assign o_din0      = r_din;

endmodule

// File: tb/tb_sram_port_sequencer.sv
// Directed bench for sram_port_sequencer with a behavioural OpenRAM port model.
// Expected values are hand-computed per scenario.
module tb_sram_port_sequencer;

    logic        clk;
    logic        resetn;
    logic        global_csb;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0;

    logic [31:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    sram_port_sequencer dut (
        .i_clk        (clk),
        .i_resetn     (resetn),
        .i_global_csb (global_csb),
        .i_req_valid  (req_valid),
        .i_req_we     (req_we),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .i_req_wmask  (req_wmask),
        .o_req_ready  (req_ready),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_data   (rsp_data),
        .o_csb0       (csb0),
        .o_web0       (web0),
        .o_wmask0     (wmask0),
        .o_addr0      (addr0),
        .o_din0       (din0),
        .i_dout0      (dout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: one-edge latency, masked byte writes.
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
                end
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [1:0] v, input logic [1:0] we,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] m0, input logic [3:0] m1);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        req_wmask = {m1, m0};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  rr_ready [4];
    logic [1:0]  rr_vld   [4];
    logic [31:0] rr_data  [4];

    initial begin
        rr_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
        rr_vld   = '{2'b01, 2'b10, 2'b01, 2'b10};
        rr_data  = '{32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D};
        dout0      = '0;
        resetn     = 1'b0;
        global_csb = 1'b0;
        drv(2'b11, 2'b11, 8'h10, 8'h20, 32'hDEADBEEF, 32'hCAFEF00D, 4'hF, 4'hF);

        // reset state with both requesters asserting
        repeat (3) begin
            tick;
            chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
            chk("rst_ready", {62'd0, req_ready}, 64'd0);
        end
        chk("rst_csb0", {63'd0, csb0}, 64'd1);
        chk("rst_web0", {63'd0, web0}, 64'd1);
        chk("rst_wmask0", {60'd0, wmask0}, 64'd0);
        chk("rst_addr0", {56'd0, addr0}, 64'd0);
        chk("rst_din0", {32'd0, din0}, 64'd0);
        chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);

        // first conflict goes to requester 0
        resetn = 1'b1;
        #1;
        chk("first_grant", {62'd0, req_ready}, 64'h1);
        tick;
        chk("wr_csb0", {63'd0, csb0}, 64'd0);
        chk("wr_web0", {63'd0, web0}, 64'd0);
        chk("wr_addr0", {56'd0, addr0}, 64'h10);
        chk("wr_din0", {32'd0, din0}, 64'hDEADBEEF);
        chk("wr_wmask0", {60'd0, wmask0}, 64'hF);

        // read-after-write from requester 0
        drv(2'b01, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0, 4'hF, 4'hF);
        #1;
        chk("rd_ready", {62'd0, req_ready}, 64'h1);
        tick;
        chk("rd_web0", {63'd0, web0}, 64'd1);
        chk("rd_wmask0", {60'd0, wmask0}, 64'd0);
        chk("rd_csb0", {63'd0, csb0}, 64'd0);
        drv(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        tick;
        chk("idle_csb0", {63'd0, csb0}, 64'd1);
        chk("rd_rsp_early", {62'd0, rsp_valid}, 64'd0);
        tick;
        chk("rd_rsp_valid", {62'd0, rsp_valid}, 64'h1);
        chk("rd_rsp_data", {32'd0, rsp_data}, 64'hDEADBEEF);
        tick;
        chk("rd_rsp_pulse", {62'd0, rsp_valid}, 64'd0);
        chk("rd_rsp_hold", {32'd0, rsp_data}, 64'hDEADBEEF);

        // requester 1 writes 0x20 alone
        drv(2'b10, 2'b10, 8'h0, 8'h20, 32'h0, 32'hCAFEF00D, 4'h0, 4'hF);
        #1;
        chk("wr1_ready", {62'd0, req_ready}, 64'h2);
        tick;

        // both reading for 4 cycles: alternate grants, in-order returns
        for (int k = 0; k < 7; k++) begin
            if (k < 4) drv(2'b11, 2'b00, 8'h10, 8'h20, 32'h0, 32'h0, 4'h0, 4'h0);
            else       drv(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
            #1;
            if (k < 4) chk($sformatf("rr_ready%0d", k), {62'd0, req_ready}, {62'd0, rr_ready[k]});
            tick;
            if (k >= 2 && k < 6) begin
                chk($sformatf("rr_rsp_valid%0d", k), {62'd0, rsp_valid}, {62'd0, rr_vld[k-2]});
                chk($sformatf("rr_rsp_data%0d", k), {32'd0, rsp_data}, {32'd0, rr_data[k-2]});
            end else begin
                chk($sformatf("rr_rsp_none%0d", k), {62'd0, rsp_valid}, 64'd0);
            end
        end

        // partial byte mask over all-ones, then immediate read
        drv(2'b10, 2'b10, 8'h0, 8'h30, 32'h0, 32'hFFFFFFFF, 4'h0, 4'hF);
        tick;
        drv(2'b10, 2'b10, 8'h0, 8'h30, 32'h0, 32'h12345678, 4'h0, 4'b0011);
        tick;
        chk("pm_wmask0", {60'd0, wmask0}, 64'h3);
        chk("pm_din0", {32'd0, din0}, 64'h12345678);
        drv(2'b10, 2'b00, 8'h0, 8'h30, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        chk("pm_rd_ready", {62'd0, req_ready}, 64'h2);
        tick;
        drv(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        tick;
        chk("pm_rsp_early", {62'd0, rsp_valid}, 64'd0);
        tick;
        chk("pm_rsp_valid", {62'd0, rsp_valid}, 64'h2);
        chk("pm_rsp_data", {32'd0, rsp_data}, 64'hFFFF5678);

        // global_csb raised with two reads in flight
        drv(2'b11, 2'b00, 8'h10, 8'h30, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        chk("gc_ready_a", {62'd0, req_ready}, 64'h1);
        tick;
        chk("gc_ready_b", {62'd0, req_ready}, 64'h2);
        tick;
        global_csb = 1'b1;
        #1;
        chk("gc_ready_hold0", {62'd0, req_ready}, 64'd0);
        tick;
        chk("gc_csb0_c", {63'd0, csb0}, 64'd1);
        chk("gc_rsp_a", {62'd0, rsp_valid}, 64'h1);
        chk("gc_data_a", {32'd0, rsp_data}, 64'hDEADBEEF);
        chk("gc_ready_hold1", {62'd0, req_ready}, 64'd0);
        tick;
        chk("gc_csb0_d", {63'd0, csb0}, 64'd1);
        chk("gc_rsp_b", {62'd0, rsp_valid}, 64'h2);
        chk("gc_data_b", {32'd0, rsp_data}, 64'hFFFF5678);
        global_csb = 1'b0;
        drv(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        tick;
        chk("gc_rsp_end", {62'd0, rsp_valid}, 64'd0);

        // reset shortly after a read accept drops the read
        drv(2'b01, 2'b00, 8'h10, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        tick;
        drv(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        @(negedge clk);
        resetn = 1'b0;
        repeat (4) begin
            tick;
            chk("mr_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        drv(2'b10, 2'b00, 8'h0, 8'h30, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        chk("mr_ready", {62'd0, req_ready}, 64'h2);
        tick;
        drv(2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        tick;
        chk("mr_rsp_early", {62'd0, rsp_valid}, 64'd0);
        tick;
        chk("mr_rsp_valid_after", {62'd0, rsp_valid}, 64'h2);
        chk("mr_rsp_data_after", {32'd0, rsp_data}, 64'hFFFF5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
